ps2_matrix: RTL
===============

PS2_MATRIX -- requirements
Module: ps2_matrix

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 kbd_key  in  8  PS/2 set-2 scan-code byte from the PS/2 receiver; stable while kbd_key_valid high.
REQ-004 kbd_key_valid  in  1  level from receiver, asynchronous to clk; rising edge marks a new byte.
REQ-005 addr_hi  in  8  CPU A15..A8; bit n low selects half-row n.
REQ-006 keyrow_n  out  5  active-low column data (bit0 = outermost key) for selected half-rows; combinational from addr_hi and matrix.
REQ-007 key_strobe  out  1  one-clk pulse when a make/break is applied to the matrix.

Function
REQ-008 kbd_key_valid SHALL pass a 2-flop synchroniser then rising-edge detect; kbd_key is captured on the detected edge.
REQ-009 Matrix = 8 rows x 5 bits, 1 = pressed; rows: 0 CS Z X C V, 1 A S D F G, 2 Q W E R T, 3 1 2 3 4 5, 4 0 9 8 7 6, 5 P O I U Y, 6 ENTER L K J H, 7 SPACE SS M N B.
REQ-010 Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (E0 then F0), SKIP (after E1).
REQ-011 IDLE: F0->BRK; E0->EXT; E1->SKIP with skip count 7; other byte = make of normal code, stay IDLE.
REQ-012 BRK: byte = break of normal code ->IDLE. EXT: F0->EXT_BRK, else make of extended code ->IDLE. EXT_BRK: break of extended code ->IDLE.
REQ-013 SKIP: discard bytes, decrement count, ->IDLE when count reaches 0 (Pause sequence dropped).
REQ-014 Unmapped codes SHALL be consumed without matrix change and without key_strobe.
REQ-015 Direct maps: letters/digits/ENTER(5A)/SPACE(29); L-shift 12 and R-shift 59 -> CS; L-ctrl 14 and E0 14 (R-ctrl) -> SS.
REQ-016 Composite keys: backspace 66 -> CS+0; E0 6B -> CS+5; E0 72 -> CS+6; E0 75 -> CS+7; E0 74 -> CS+8.
REQ-017 CS bit SHALL be OR of physical-shift flag and five composite flags; releasing one source never clears CS held by another.
REQ-018 Composite base key (0,5,6,7,8) likewise OR of its direct and composite sources.
REQ-019 Make of an already-pressed key and break of a released key SHALL be idempotent.
REQ-020 Bytes AA (BAT), 00 and FF (overrun) in any state SHALL clear all matrix bits and flags, return FSM to IDLE, no key_strobe.
REQ-021 Latency: matrix and key_strobe update on the 4th rising clk edge after kbd_key_valid is first sampled high; one byte per valid edge.
REQ-022 keyrow_n[c] = NOT (OR over rows r with addr_hi[r]=0 of matrix[r][c]); addr_hi = FF gives 1F.

Reset
REQ-023 reset_n low at a rising edge: FSM IDLE, skip count 0, matrix and flags 0, synchroniser 0, key_strobe 0; keyrow_n then 1F.
REQ-024 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; next byte decoded from IDLE.

Structure
REQ-025 Shared package ps2_pkg: FSM state enum, prefix constants F0/E0/E1/AA, half-row/column index constants, skip count 7.
REQ-026 Scan-code lookup (code, ext -> valid, row, col, composite index) SHALL be sub-module ps2_keymap, purely combinational.

Verification
REQ-027 1C -> row1 bit0 set; addr_hi FD -> keyrow_n 1E; then F0 1C -> keyrow_n 1F; two key_strobe pulses.
REQ-028 12 make, E0 6B make, 12 break -> addr_hi FE gives 1E (CS held), F7 gives 0F; E0 F0 6B -> both 1F.
REQ-029 16 and 45 made, addr_hi E7 -> keyrow_n 1E (rows 3,4 ORed); AA -> all rows 1F, no strobe.
REQ-030 E1 14 77 E1 F0 14 F0 77 then 15 -> only Q pressed (row2 bit0), one strobe total.
REQ-031 E0 then reset_n low 1 clk then 6B -> no key change (6B unmapped as normal code), FSM IDLE.
REQ-032 kbd_key_valid raised asynchronously to clk -> key_strobe exactly 4 edges later, once per rising edge of valid.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 to key-matrix bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } ps2_state_t;

  localparam logic [7:0] c_CODE_F0 = 8'hF0;
  localparam logic [7:0] c_CODE_E0 = 8'hE0;
  localparam logic [7:0] c_CODE_E1 = 8'hE1;
  localparam logic [7:0] c_CODE_AA = 8'hAA;
  localparam logic [7:0] c_CODE_00 = 8'h00;
  localparam logic [7:0] c_CODE_FF = 8'hFF;

  localparam int c_NUM_ROWS = 8;
  localparam int c_NUM_COLS = 5;

  localparam logic [2:0] c_ROW_CS  = 3'd0;
  localparam logic [2:0] c_ROW_AG  = 3'd1;
  localparam logic [2:0] c_ROW_QT  = 3'd2;
  localparam logic [2:0] c_ROW_15  = 3'd3;
  localparam logic [2:0] c_ROW_06  = 3'd4;
  localparam logic [2:0] c_ROW_PY  = 3'd5;
  localparam logic [2:0] c_ROW_ENT = 3'd6;
  localparam logic [2:0] c_ROW_SPC = 3'd7;

  localparam logic [2:0] c_COL_0 = 3'd0;
  localparam logic [2:0] c_COL_1 = 3'd1;
  localparam logic [2:0] c_COL_2 = 3'd2;
  localparam logic [2:0] c_COL_3 = 3'd3;
  localparam logic [2:0] c_COL_4 = 3'd4;

  localparam logic [2:0] c_SKIP_COUNT = 3'd7;

  // Composite key index; flag bit in the top level is (index - 1).
  localparam logic [2:0] c_COMP_NONE  = 3'd0;
  localparam logic [2:0] c_COMP_BKSP  = 3'd1;
  localparam logic [2:0] c_COMP_LEFT  = 3'd2;
  localparam logic [2:0] c_COMP_DOWN  = 3'd3;
  localparam logic [2:0] c_COMP_UP    = 3'd4;
  localparam logic [2:0] c_COMP_RIGHT = 3'd5;

  function automatic logic is_clear_code(input logic [7:0] b);
    return (b == c_CODE_AA) || (b == c_CODE_00) || (b == c_CODE_FF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keymap.sv
// ============================================================================
// Module      : ps2_keymap
// Description : Combinational set-2 scan code to matrix position lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output logic       o_valid,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_shift,
  output logic [2:0] o_comp
);

  logic [6:0] w_rc;

  always_comb begin
    w_rc    = 7'd0;
    o_shift = 1'b0;
    o_comp  = c_COMP_NONE;
    if (!i_ext) begin
      case (i_code)
        8'h1A: w_rc = {1'b1, c_ROW_CS,  c_COL_1};
        8'h22: w_rc = {1'b1, c_ROW_CS,  c_COL_2};
        8'h21: w_rc = {1'b1, c_ROW_CS,  c_COL_3};
        8'h2A: w_rc = {1'b1, c_ROW_CS,  c_COL_4};
        8'h1C: w_rc = {1'b1, c_ROW_AG,  c_COL_0};
        8'h1B: w_rc = {1'b1, c_ROW_AG,  c_COL_1};
        8'h23: w_rc = {1'b1, c_ROW_AG,  c_COL_2};
        8'h2B: w_rc = {1'b1, c_ROW_AG,  c_COL_3};
        8'h34: w_rc = {1'b1, c_ROW_AG,  c_COL_4};
        8'h15: w_rc = {1'b1, c_ROW_QT,  c_COL_0};
        8'h1D: w_rc = {1'b1, c_ROW_QT,  c_COL_1};
        8'h24: w_rc = {1'b1, c_ROW_QT,  c_COL_2};
        8'h2D: w_rc = {1'b1, c_ROW_QT,  c_COL_3};
        8'h2C: w_rc = {1'b1, c_ROW_QT,  c_COL_4};
        8'h16: w_rc = {1'b1, c_ROW_15,  c_COL_0};
        8'h1E: w_rc = {1'b1, c_ROW_15,  c_COL_1};
        8'h26: w_rc = {1'b1, c_ROW_15,  c_COL_2};
        8'h25: w_rc = {1'b1, c_ROW_15,  c_COL_3};
        8'h2E: w_rc = {1'b1, c_ROW_15,  c_COL_4};
        8'h45: w_rc = {1'b1, c_ROW_06,  c_COL_0};
        8'h46: w_rc = {1'b1, c_ROW_06,  c_COL_1};
        8'h3E: w_rc = {1'b1, c_ROW_06,  c_COL_2};
        8'h3D: w_rc = {1'b1, c_ROW_06,  c_COL_3};
        8'h36: w_rc = {1'b1, c_ROW_06,  c_COL_4};
        8'h4D: w_rc = {1'b1, c_ROW_PY,  c_COL_0};
        8'h44: w_rc = {1'b1, c_ROW_PY,  c_COL_1};
        8'h43: w_rc = {1'b1, c_ROW_PY,  c_COL_2};
        8'h3C: w_rc = {1'b1, c_ROW_PY,  c_COL_3};
        8'h35: w_rc = {1'b1, c_ROW_PY,  c_COL_4};
        8'h5A: w_rc = {1'b1, c_ROW_ENT, c_COL_0};
        8'h4B: w_rc = {1'b1, c_ROW_ENT, c_COL_1};
        8'h42: w_rc = {1'b1, c_ROW_ENT, c_COL_2};
        8'h3B: w_rc = {1'b1, c_ROW_ENT, c_COL_3};
        8'h33: w_rc = {1'b1, c_ROW_ENT, c_COL_4};
        8'h29: w_rc = {1'b1, c_ROW_SPC, c_COL_0};
        8'h14: w_rc = {1'b1, c_ROW_SPC, c_COL_1};
        8'h3A: w_rc = {1'b1, c_ROW_SPC, c_COL_2};
        8'h31: w_rc = {1'b1, c_ROW_SPC, c_COL_3};
        8'h32: w_rc = {1'b1, c_ROW_SPC, c_COL_4};
        8'h12, 8'h59: begin
          w_rc    = {1'b1, c_ROW_CS, c_COL_0};
          o_shift = 1'b1;
        end
        8'h66: begin
          w_rc   = {1'b1, c_ROW_06, c_COL_0};
          o_comp = c_COMP_BKSP;
        end
        default: w_rc = 7'd0;
      endcase
    end else begin
      case (i_code)
        8'h14: w_rc = {1'b1, c_ROW_SPC, c_COL_1};
        8'h6B: begin w_rc = {1'b1, c_ROW_15, c_COL_4}; o_comp = c_COMP_LEFT;  end
        8'h72: begin w_rc = {1'b1, c_ROW_06, c_COL_4}; o_comp = c_COMP_DOWN;  end
        8'h75: begin w_rc = {1'b1, c_ROW_06, c_COL_3}; o_comp = c_COMP_UP;    end
        8'h74: begin w_rc = {1'b1, c_ROW_06, c_COL_2}; o_comp = c_COMP_RIGHT; end
        default: w_rc = 7'd0;
      endcase
    end
  end

  assign o_valid = w_rc[6];
  assign o_row   = w_rc[5:3];
  assign o_col   = w_rc[2:0];

endmodule

`default_nettype wire

// File: rtl/ps2_matrix.sv
// ============================================================================
// Module      : ps2_matrix
// Description : PS/2 set-2 scan-code decoder driving an 8x5 key matrix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_matrix
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] kbd_key,
  input  logic       kbd_key_valid,
  input  logic [7:0] addr_hi,
  output logic [4:0] keyrow_n,
  output logic       key_strobe
);

  logic             r_sync1, r_sync2, r_sync3;
  logic             r_byte_vld;
  logic [7:0]       r_byte;
  ps2_state_t       r_state;
  logic [2:0]       r_skip;
  logic [7:0][4:0]  r_matrix;
  logic             r_shift;
  logic [4:0]       r_comp;
  logic             r_strobe;

  logic             w_rise;
  logic             w_ext, w_make, w_decode, w_apply, w_clear;
  logic             w_km_valid, w_km_shift;
  logic [2:0]       w_km_row, w_km_col, w_km_comp;
  logic [7:0][4:0]  w_mat;
  logic [4:0]       w_sel;

  assign w_rise  = r_sync2 & ~r_sync3;
  assign w_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_make  = (r_state == ST_IDLE) || (r_state == ST_EXT);
  assign w_clear = r_byte_vld && is_clear_code(r_byte);

  // Bytes that are real key codes for the current state (not prefixes).
  always_comb begin
    w_decode = 1'b0;
    case (r_state)
      ST_IDLE:    w_decode = (r_byte != c_CODE_F0) && (r_byte != c_CODE_E0) &&
                             (r_byte != c_CODE_E1);
      ST_BRK:     w_decode = 1'b1;
      ST_EXT:     w_decode = (r_byte != c_CODE_F0);
      ST_EXT_BRK: w_decode = 1'b1;
      default:    w_decode = 1'b0;
    endcase
  end

  assign w_apply = r_byte_vld && !w_clear && w_decode && w_km_valid;

  ps2_keymap u_keymap (
    .i_code  (r_byte),
    .i_ext   (w_ext),
    .o_valid (w_km_valid),
    .o_row   (w_km_row),
    .o_col   (w_km_col),
    .o_shift (w_km_shift),
    .o_comp  (w_km_comp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= 8'd0;
      r_state    <= ST_IDLE;
      r_skip     <= 3'd0;
      r_matrix   <= '0;
      r_shift    <= 1'b0;
      r_comp     <= 5'd0;
      r_strobe   <= 1'b0;
    end else begin
      r_sync1    <= kbd_key_valid;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      r_byte_vld <= w_rise;
      if (w_rise) r_byte <= kbd_key;
      r_strobe   <= w_apply;

      if (w_apply) begin
        if (w_km_shift)
          r_shift <= w_make;
        else if (w_km_comp != c_COMP_NONE)
          r_comp[w_km_comp - 3'd1] <= w_make;
        else
          r_matrix[w_km_row][w_km_col] <= w_make;
      end

      if (w_clear) begin
        r_state  <= ST_IDLE;
        r_skip   <= 3'd0;
        r_matrix <= '0;
        r_shift  <= 1'b0;
        r_comp   <= 5'd0;
      end else if (r_byte_vld) begin
        case (r_state)
          ST_IDLE: begin
            if (r_byte == c_CODE_F0)      r_state <= ST_BRK;
            else if (r_byte == c_CODE_E0) r_state <= ST_EXT;
            else if (r_byte == c_CODE_E1) begin
              r_state <= ST_SKIP;
              r_skip  <= c_SKIP_COUNT;
            end
          end
          ST_BRK:     r_state <= ST_IDLE;
          ST_EXT:     r_state <= (r_byte == c_CODE_F0) ? ST_EXT_BRK : ST_IDLE;
          ST_EXT_BRK: r_state <= ST_IDLE;
          ST_SKIP: begin
            r_skip <= (r_skip == 3'd0) ? 3'd0 : r_skip - 3'd1;
            if (r_skip <= 3'd1) r_state <= ST_IDLE;
          end
          default:    r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Shared keys (CS and composite bases) are the OR of every source holding them.
  always_comb begin
    w_mat = r_matrix;
    w_mat[c_ROW_CS][c_COL_0] = r_matrix[c_ROW_CS][c_COL_0] | r_shift | (|r_comp);
    w_mat[c_ROW_06][c_COL_0] = r_matrix[c_ROW_06][c_COL_0] | r_comp[0];
    w_mat[c_ROW_15][c_COL_4] = r_matrix[c_ROW_15][c_COL_4] | r_comp[1];
    w_mat[c_ROW_06][c_COL_4] = r_matrix[c_ROW_06][c_COL_4] | r_comp[2];
    w_mat[c_ROW_06][c_COL_3] = r_matrix[c_ROW_06][c_COL_3] | r_comp[3];
    w_mat[c_ROW_06][c_COL_2] = r_matrix[c_ROW_06][c_COL_2] | r_comp[4];
  end

  always_comb begin
    w_sel = 5'd0;
    for (int r = 0; r < c_NUM_ROWS; r++) begin
      if (!addr_hi[r]) w_sel = w_sel | w_mat[r];
    end
  end

  assign keyrow_n   = ~w_sel;
  assign key_strobe = r_strobe;

endmodule

`default_nettype wire
